// File: rtl/display_bank_pkg.sv
// Shared types and constants for the AXI-Lite display register bank.
package display_bank_pkg;

    localparam int STATUS_CNT_W = 32;
    localparam int MMIO_ADDR_W  = 64;
    localparam int MMIO_DATA_W  = 64;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAITD,
        W_WAITA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_e;

    typedef struct packed {
        logic                   valid;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_DATA_W-1:0] data;
    } mmio_rec_t;

    // Width of a channel select; a single-channel bank still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_bank_regfile.sv
// Display register storage: address decode, byte-merge on write, commit
// counter / last-channel status, display mux and the MMIO commit record.
module display_bank_regfile
    import display_bank_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              ADDR_W    = 64,
    parameter int              NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              SEL_W     = sel_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_hit,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_hit,
    input  logic [SEL_W-1:0]      disp_sel,
    output logic [DATA_W-1:0]     display_o,
    output mmio_rec_t             mmio
);

    localparam int IDX_W  = ADDR_W - 3;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [IDX_W-1:0] CH_IDX = IDX_W'(NUM_CH);

    logic [NUM_CH-1:0][DATA_W-1:0] regs;
    logic [STATUS_CNT_W-1:0]       cnt;
    logic [3:0]                    last_ch;
    logic [IDX_W-1:0]              wr_idx, rd_idx;
    logic [SEL_W-1:0]              wr_ch, rd_ch;
    logic [DATA_W-1:0]             old_val, merged, status;

    // Byte offset bits [2:0] fall away in the shift.
    assign wr_idx = IDX_W'((wr_addr - BASE_ADDR) >> 3);
    assign rd_idx = IDX_W'((rd_addr - BASE_ADDR) >> 3);
    assign wr_ch  = wr_idx[SEL_W-1:0];
    assign rd_ch  = rd_idx[SEL_W-1:0];
    assign wr_hit = (wr_idx < CH_IDX);

    assign old_val = regs[wr_ch];
    assign status  = {24'b0, last_ch, 4'b0, cnt};

    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign merged[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : old_val[8*b +: 8];
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        if (rd_idx < CH_IDX)
            rd_data = regs[rd_ch];
        else if (rd_idx == CH_IDX)
            rd_data = status;
        else
            rd_hit = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs      <= '0;
            cnt       <= '0;
            last_ch   <= '0;
            mmio      <= '0;
            display_o <= '0;
        end else begin
            mmio.valid <= 1'b0;
            if (wr_en && wr_hit) begin
                regs[wr_ch] <= merged;
                cnt         <= cnt + 1'b1;
                last_ch     <= 4'(wr_ch);
                mmio        <= '{valid: 1'b1,
                                 addr:  MMIO_ADDR_W'(wr_addr),
                                 data:  MMIO_DATA_W'(merged)};
            end
            display_o <= (32'(disp_sel) < NUM_CH) ? regs[disp_sel] : '0;
        end
    end

endmodule

// File: rtl/axi_lite_display_bank.sv
// AXI4-Lite slave front end for the display bank: independent write and
// read handshake FSMs around display_bank_regfile.
module axi_lite_display_bank
    import display_bank_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                SEL_W     = sel_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [SEL_W-1:0]    disp_sel,
    output logic [DATA_W-1:0]   display_o,
    output logic                mmio_valid,
    output logic [ADDR_W-1:0]   mmio_addr,
    output logic [DATA_W-1:0]   mmio_data
);

    wstate_e             wstate, wnext;
    rstate_e             rstate, rnext;
    logic [ADDR_W-1:0]   aw_addr_q, c_addr;
    logic [DATA_W-1:0]   w_data_q, c_data, rd_data;
    logic [DATA_W/8-1:0] w_strb_q, c_strb;
    logic                commit, wr_hit, rd_hit;
    mmio_rec_t           mmio;

    // Commit takes whichever half is live on the bus and the other from its latch.
    always_comb begin
        wnext   = wstate;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        commit  = 1'b0;
        c_addr  = aw_addr_q;
        c_data  = w_data_q;
        c_strb  = w_strb_q;
        case (wstate)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                c_addr  = awaddr;
                c_data  = wdata;
                c_strb  = wstrb;
                if (awvalid && wvalid) begin
                    commit = 1'b1;
                    wnext  = W_RESP;
                end else if (awvalid) begin
                    wnext = W_WAITD;
                end else if (wvalid) begin
                    wnext = W_WAITA;
                end
            end
            W_WAITD: begin
                wready = 1'b1;
                c_data = wdata;
                c_strb = wstrb;
                if (wvalid) begin
                    commit = 1'b1;
                    wnext  = W_RESP;
                end
            end
            W_WAITA: begin
                awready = 1'b1;
                c_addr  = awaddr;
                if (awvalid) begin
                    commit = 1'b1;
                    wnext  = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    wnext = W_IDLE;
            end
            default: wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= OKAY;
        end else begin
            wstate <= wnext;
            if (awready && awvalid)
                aw_addr_q <= awaddr;
            if (wready && wvalid) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit)
                bresp <= wr_hit ? OKAY : SLVERR;
        end
    end

    always_comb begin
        rnext   = rstate;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid)
                    rnext = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready)
                    rnext = R_IDLE;
            end
            default: rnext = R_IDLE;
        endcase
    end

    // Read data is sampled before any same-edge commit lands, so it sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate <= R_IDLE;
            rdata  <= '0;
            rresp  <= OKAY;
        end else begin
            rstate <= rnext;
            if (arready && arvalid) begin
                rdata <= rd_hit ? rd_data : '0;
                rresp <= rd_hit ? OKAY : SLVERR;
            end
        end
    end

    display_bank_regfile #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR),
        .SEL_W     (SEL_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (commit),
        .wr_addr   (c_addr),
        .wr_data   (c_data),
        .wr_strb   (c_strb),
        .wr_hit    (wr_hit),
        .rd_addr   (araddr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .disp_sel  (disp_sel),
        .display_o (display_o),
        .mmio      (mmio)
    );

    assign mmio_valid = mmio.valid;
    assign mmio_addr  = mmio.addr[ADDR_W-1:0];
    assign mmio_data  = mmio.data[DATA_W-1:0];

endmodule
